fp_add_scheduler: RTL and testbench
===================================

Name: fp_add_scheduler

Overview:
- Round-robin scheduler that shares one combinational FP32 adder (FloatingAddition instance, external) between NREQ requesters, e.g. the cell-voltage summation and SoC-integration paths.
- Accepts operand pairs over a valid/ready handshake and registers them into the adder.
- Captures the sum one cycle later and returns it with the requester ID over a valid/ready response channel.
- Detects zero and exact-cancellation operands and bypasses the adder for them, because the adder does not handle zero.

Parameters:
- XLEN, 32, operand/result width (IEEE-754 single).
- NREQ, 4, number of requesters (2..8).
- IDW, 2, width of requester ID; must satisfy 2^IDW >= NREQ.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- req_valid  in  NREQ  per-requester request valid.
- req_a  in  NREQ*XLEN  operand A; requester i occupies bits [i*XLEN +: XLEN].
- req_b  in  NREQ*XLEN  operand B; same packing as req_a.
- req_ready  out  NREQ  one-hot accept strobe.
- resp_valid  out  1  result valid.
- resp_id  out  IDW  requester index of the result.
- resp_result  out  XLEN  sum.
- resp_ready  in  1  downstream accepts result.
- add_a  out  XLEN  registered operand to the adder A input.
- add_b  out  XLEN  registered operand to the adder B input.
- add_result  in  XLEN  adder result (combinational from add_a/add_b).
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values (async, rst=1):
  - state=IDLE; req_ready=0; resp_valid=0; resp_id=0; resp_result=0; add_a=0; add_b=0; busy=0.
  - Round-robin pointer last_grant=NREQ-1, so requester 0 has top priority after reset.
- States: IDLE, EXEC, RESP.
- IDLE:
  - grant = first i with req_valid[i]=1, searching from last_grant+1 upward with wrap modulo NREQ.
  - req_ready[grant]=1 combinationally, in IDLE only; all other bits are 0. No grant means req_ready=0.
  - On the clock edge with a grant:
    - latch operands into add_a/add_b; latch resp_id=grant; last_grant=grant.
    - classify bypass from the latched operands (below).
    - go to EXEC.
- EXEC (1 cycle):
  - add_a/add_b are held stable.
  - At the end of the cycle, resp_result = bypass value if bypass is set, else add_result.
  - Set resp_valid=1 and go to RESP.
- RESP:
  - resp_valid, resp_id and resp_result are held stable until resp_ready=1.
  - On that edge: resp_valid=0 and go to IDLE.
  - A new request is not accepted in the same cycle; the earliest next accept is the following IDLE cycle.
- Latency and throughput:
  - The accept edge is cycle 0; resp_valid is high from cycle 2.
  - Minimum issue interval is 3 cycles with resp_ready held high.
- Bypass rules (bits [30:0] == 0 means zero, sign ignored):
  - A zero and B zero -> result 32'h00000000.
  - A zero -> result B. B zero -> result A.
  - A[30:0]==B[30:0] and A[31]!=B[31] -> result 32'h00000000 (+0).
  - Otherwise the adder result is used unmodified.
- Fairness: a requester that is granted has the lowest priority on the next arbitration. With all NREQ requesters valid, grants rotate 0,1,2,3,0,...
- Requesters may drop req_valid before being granted; this has no effect on the scheduler.
- Operands only need to be valid in the cycle where req_ready is 1.
- rst asserted mid-operation: the in-flight operation is abandoned, no response is produced, and all outputs return to reset values immediately.
- Only one operation is in flight; the scheduler does no buffering beyond one result.

Test Plan:
- Single request: req_valid[1]=1, A=32'h3F800000, B=32'h40000000 -> req_ready=4'b0010 for 1 cycle; resp_valid 2 cycles later with resp_id=1 and resp_result=32'h40400000.
- All four requesters valid continuously, resp_ready=1 -> grant order 0,1,2,3,0; each response carries the matching ID; accepts are spaced exactly 3 cycles apart.
- Backpressure: resp_ready=0 for 5 cycles after resp_valid -> resp_result/resp_id stable, req_ready stays 0, busy=1; the next accept comes one cycle after resp_ready=1.
- Bypass: A=32'h00000000, B=32'hC0A00000 -> result 32'hC0A00000; A=32'h41200000, B=32'hC1200000 -> result 32'h00000000, with no dependence on add_result (bench drives add_result=32'hDEADBEEF).
- Reset mid-operation: assert rst during EXEC -> resp_valid=0 with no response emitted; after release, req_valid[3] and req_valid[0] both high -> requester 0 is granted first.

Source files
------------

// File: rtl/fp_add_scheduler.sv
// Round-robin scheduler that time-shares one external combinational FP32 adder
// between NREQ requesters. Zero and exact-cancellation operands bypass the adder.
module fp_add_scheduler #(
  parameter int XLEN = 32,
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*XLEN-1:0] req_a,
  input  logic [NREQ*XLEN-1:0] req_b,
  output logic [NREQ-1:0]      req_ready,
  output logic                 resp_valid,
  output logic [IDW-1:0]       resp_id,
  output logic [XLEN-1:0]      resp_result,
  input  logic                 resp_ready,
  output logic [XLEN-1:0]      add_a,
  output logic [XLEN-1:0]      add_b,
  input  logic [XLEN-1:0]      add_result,
  output logic                 busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t          state, state_next;
  logic [IDW-1:0]  last_grant;
  logic [IDW-1:0]  grant_idx, hi_idx, lo_idx;
  logic            grant_found, hi_found, lo_found;
  logic [XLEN-1:0] sel_a, sel_b;
  logic            a_zero, b_zero, cancel;
  logic            bypass_next, bypass;
  logic [XLEN-1:0] bypass_val_next, bypass_val;

  // Requesters above last_grant win over those at or below it; the descending
  // scan leaves the lowest index in each group.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        if (i > int'(last_grant)) begin
          hi_found = 1'b1;
          hi_idx   = IDW'(i);
        end else begin
          lo_found = 1'b1;
          lo_idx   = IDW'(i);
        end
      end
    end
    grant_found = hi_found | lo_found;
    grant_idx   = hi_found ? hi_idx : lo_idx;
  end

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_idx == IDW'(i)) begin
        sel_a = req_a[i*XLEN +: XLEN];
        sel_b = req_b[i*XLEN +: XLEN];
      end
    end
  end

  assign a_zero = (sel_a[XLEN-2:0] == '0);
  assign b_zero = (sel_b[XLEN-2:0] == '0);
  assign cancel = (sel_a[XLEN-2:0] == sel_b[XLEN-2:0]) && (sel_a[XLEN-1] != sel_b[XLEN-1]);

  // The adder cannot handle zero, so these cases are resolved here.
  always_comb begin
    bypass_next     = 1'b1;
    bypass_val_next = '0;
    if (a_zero && b_zero) begin
      bypass_val_next = '0;
    end else if (a_zero) begin
      bypass_val_next = sel_b;
    end else if (b_zero) begin
      bypass_val_next = sel_a;
    end else if (cancel) begin
      bypass_val_next = '0;
    end else begin
      bypass_next = 1'b0;
    end
  end

  always_comb begin
    state_next = state;
    req_ready  = '0;
    case (state)
      IDLE: begin
        if (grant_found) state_next = EXEC;
        for (int i = 0; i < NREQ; i++)
          req_ready[i] = !rst && grant_found && (grant_idx == IDW'(i));
      end
      EXEC:    state_next = RESP;
      RESP:    if (resp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant  <= IDW'(NREQ - 1);
      add_a       <= '0;
      add_b       <= '0;
      resp_id     <= '0;
      resp_result <= '0;
      resp_valid  <= 1'b0;
      bypass      <= 1'b0;
      bypass_val  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_found) begin
            add_a      <= sel_a;
            add_b      <= sel_b;
            resp_id    <= grant_idx;
            last_grant <= grant_idx;
            bypass     <= bypass_next;
            bypass_val <= bypass_val_next;
          end
        end
        EXEC: begin
          resp_result <= bypass ? bypass_val : add_result;
          resp_valid  <= 1'b1;
        end
        RESP: begin
          if (resp_ready) resp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_fp_add_scheduler.sv
// Scoreboard bench for fp_add_scheduler: accepts push expected responses,
// a negedge monitor pops and compares every delivered result.
module tb_fp_add_scheduler;
  localparam int XLEN = 32;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ*XLEN-1:0] req_a, req_b;
  logic [NREQ-1:0]      req_ready;
  logic                 resp_valid;
  logic [IDW-1:0]       resp_id;
  logic [XLEN-1:0]      resp_result;
  logic                 resp_ready;
  logic [XLEN-1:0]      add_a, add_b, add_result;
  logic                 busy;

  typedef struct {
    logic [IDW-1:0]  id;
    logic [XLEN-1:0] res;
  } exp_t;

  exp_t            sb_q[$];
  logic [XLEN-1:0] exp_res[NREQ];
  int              acc_cycle[$];
  int              acc_id[$];
  int              rv_cycle[$];
  int              checks = 0, errors = 0;
  int              cyc = 0, acc_count = 0, resp_count = 0;
  logic            prev_valid = 1'b0;

  // Stand-in adder: only knows the sums used below, anything else is junk.
  function automatic logic [XLEN-1:0] fake_add(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    if (a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
    if (a == 32'h40000000 && b == 32'h40400000) return 32'h40A00000;
    if (a == 32'h3F800000 && b == 32'h3F800000) return 32'h40000000;
    if (a == 32'h40400000 && b == 32'h40800000) return 32'h40E00000;
    return 32'hDEADBEEF;
  endfunction

  assign add_result = fake_add(add_a, add_b);

  fp_add_scheduler #(.XLEN(XLEN), .NREQ(NREQ), .IDW(IDW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_id(resp_id),
    .resp_result(resp_result), .resp_ready(resp_ready), .add_a(add_a),
    .add_b(add_b), .add_result(add_result), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Accept monitor: the handshake completes on the next rising edge.
  always @(negedge clk) begin
    int gi;
    if (!rst && req_ready != '0) begin
      gi = 0;
      for (int i = 0; i < NREQ; i++) if (req_ready[i]) gi = i;
      check_output("req_ready_onehot", $countones(req_ready), 1);
      check_output("req_ready_has_valid", {31'd0, req_valid[gi]}, 1);
      acc_count++;
      acc_cycle.push_back(cyc);
      acc_id.push_back(gi);
      sb_q.push_back('{IDW'(gi), exp_res[gi]});
    end
  end

  // Response monitor
  always @(negedge clk) begin
    exp_t e;
    if (!rst && resp_valid && !prev_valid) rv_cycle.push_back(cyc);
    prev_valid = resp_valid;
    if (!rst && resp_valid && resp_ready) begin
      if (sb_q.size() == 0) begin
        check_output("resp_unexpected", {31'd0, resp_valid}, 0);
      end else begin
        e = sb_q.pop_front();
        check_output("resp_id", {30'd0, resp_id}, {30'd0, e.id});
        check_output("resp_result", resp_result, e.res);
        resp_count++;
      end
    end
  end

  task automatic apply_stimulus(input int id, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] exp);
    req_a[id*XLEN +: XLEN] = a;
    req_b[id*XLEN +: XLEN] = b;
    exp_res[id]    = exp;
    req_valid[id]  = 1'b1;
  endtask

  task automatic wait_acc(input int n, input string name);
    int t = 0;
    while (acc_count < n && t < 60) begin
      @(posedge clk);
      t++;
    end
    #1;
    check_output({name, "_accept_seen"}, acc_count, n);
  endtask

  task automatic wait_resp(input int n, input string name);
    int t = 0;
    while (resp_count < n && t < 60) begin
      @(posedge clk);
      t++;
    end
    #1;
    check_output({name, "_resp_seen"}, resp_count, n);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation timed out");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int base, r, rbase, t;
    logic [IDW-1:0]  hold_id;
    logic [XLEN-1:0] hold_res;

    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; resp_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) exp_res[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    check_output("rst_resp_valid", {31'd0, resp_valid}, 0);
    check_output("rst_busy", {31'd0, busy}, 0);
    check_output("rst_req_ready", {28'd0, req_ready}, 0);
    check_output("rst_add_a", add_a, 0);
    check_output("rst_add_b", add_b, 0);
    check_output("rst_resp_id", {30'd0, resp_id}, 0);
    check_output("rst_resp_result", resp_result, 0);
    rst = 1'b0;

    // Single request from requester 1: 1.0 + 2.0 = 3.0
    @(posedge clk); #1;
    apply_stimulus(1, 32'h3F800000, 32'h40000000, 32'h40400000);
    #1;
    check_output("single_req_ready", {28'd0, req_ready}, 32'h2);
    wait_acc(1, "single");
    req_valid = '0;
    check_output("single_ready_drops", {28'd0, req_ready}, 0);
    check_output("single_busy", {31'd0, busy}, 1);
    check_output("single_add_a", add_a, 32'h3F800000);
    check_output("single_add_b", add_b, 32'h40000000);
    wait_resp(1, "single");
    check_output("single_latency", rv_cycle[$] - acc_cycle[$], 2);

    // All four valid; last grant was 1, so rotation starts at 2
    @(posedge clk); #1;
    base = acc_count;
    rbase = resp_count;
    apply_stimulus(0, 32'h3F800000, 32'h40000000, 32'h40400000);
    apply_stimulus(1, 32'h40000000, 32'h40400000, 32'h40A00000);
    apply_stimulus(2, 32'h3F800000, 32'h3F800000, 32'h40000000);
    apply_stimulus(3, 32'h40400000, 32'h40800000, 32'h40E00000);
    wait_acc(base + 5, "rr");
    req_valid = '0;
    wait_resp(rbase + 5, "rr");
    for (int k = 0; k < 5; k++)
      check_output($sformatf("rr_grant_%0d", k), acc_id[base + k], (2 + k) % NREQ);
    for (int k = 0; k < 4; k++)
      check_output($sformatf("rr_spacing_%0d", k), acc_cycle[base + k + 1] - acc_cycle[base + k], 3);

    // Backpressure with a zero-bypass request pending behind it
    @(posedge clk); #1;
    resp_ready = 1'b0;
    base = acc_count;
    rbase = resp_count;
    apply_stimulus(0, 32'h40000000, 32'h40400000, 32'h40A00000);
    wait_acc(base + 1, "bp");
    req_valid = '0;
    apply_stimulus(2, 32'h00000000, 32'hC0A00000, 32'hC0A00000);
    t = 0;
    while (!resp_valid && t < 10) begin
      @(posedge clk); #1;
      t++;
    end
    check_output("bp_valid_seen", {31'd0, resp_valid}, 1);
    hold_id  = resp_id;
    hold_res = resp_result;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check_output("bp_valid_held", {31'd0, resp_valid}, 1);
      check_output("bp_id_stable", {30'd0, resp_id}, {30'd0, hold_id});
      check_output("bp_result_stable", resp_result, hold_res);
      check_output("bp_req_ready", {28'd0, req_ready}, 0);
      check_output("bp_busy", {31'd0, busy}, 1);
    end
    resp_ready = 1'b1;
    r = cyc;
    wait_acc(base + 2, "bp_next");
    req_valid = '0;
    check_output("bp_next_id", acc_id[$], 2);
    check_output("bp_next_delay", acc_cycle[$] - r, 1);
    wait_resp(rbase + 2, "bp");

    // Cancellation and zero cases must ignore the junk adder output
    @(posedge clk); #1;
    rbase = resp_count;
    apply_stimulus(3, 32'h41200000, 32'hC1200000, 32'h00000000);
    wait_acc(acc_count + 1, "cancel");
    req_valid = '0;
    apply_stimulus(1, 32'h40400000, 32'h80000000, 32'h40400000);
    wait_acc(acc_count + 1, "bzero");
    req_valid = '0;
    apply_stimulus(0, 32'h80000000, 32'h00000000, 32'h00000000);
    wait_acc(acc_count + 1, "bothzero");
    req_valid = '0;
    wait_resp(rbase + 3, "bypass");

    // Reset while in EXEC: nothing may come out, then requester 0 wins
    @(posedge clk); #1;
    apply_stimulus(1, 32'h3F800000, 32'h40000000, 32'h40400000);
    wait_acc(acc_count + 1, "rstmid");
    req_valid = '0;
    rst = 1'b1;
    #1;
    sb_q.delete();
    check_output("rstmid_resp_valid", {31'd0, resp_valid}, 0);
    check_output("rstmid_busy", {31'd0, busy}, 0);
    check_output("rstmid_add_a", add_a, 0);
    apply_stimulus(3, 32'h40400000, 32'h40800000, 32'h40E00000);
    apply_stimulus(0, 32'h3F800000, 32'h3F800000, 32'h40000000);
    #1;
    check_output("rstmid_req_ready", {28'd0, req_ready}, 0);
    repeat (2) @(posedge clk);
    #1;
    check_output("rstmid_no_resp", {31'd0, resp_valid}, 0);
    rst = 1'b0;
    rbase = resp_count;
    base = acc_count;
    wait_acc(base + 1, "after_rst");
    req_valid[0] = 1'b0;
    check_output("after_rst_first", acc_id[$], 0);
    wait_acc(base + 2, "after_rst2");
    req_valid = '0;
    check_output("after_rst_second", acc_id[$], 3);
    wait_resp(rbase + 2, "after_rst");

    repeat (3) @(posedge clk);
    #1;
    check_output("sb_empty", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
